truth_table_sweeper: RTL and testbench

- Exhaustively drives every input combination of an N-input combinational gate netlist, such as the 3-input NOR/NOT Cello logic circuits, and reads back the truth table it implements.
- Packs the result in the team's hex truth-table convention and compares it against an expected value.
- Sits in the circuit-scoring testbench/FPGA harness as the read-back counterpart to synthesized designs.
- The netlist under test is combinational and clocked by nothing; this block owns all sequencing.

---
 rtl/truth_table_sweeper_if.sv | 24 ++
 rtl/truth_table_sweeper.sv | 126 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Control/status and netlist-drive signals of the truth-table sweeper; master is the harness, slave the sweeper.
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    logic                   start;
    logic [(1<<N_IN)-1:0]   expected;
    logic                   dut_out;
    logic [N_IN-1:0]        stim;
    logic                   busy;
    logic                   done;
    logic [(1<<N_IN)-1:0]   result;
    logic                   match;
    logic                   unstable;

    modport master (
        output start, expected, dut_out,
        input  stim, busy, done, result, match, unstable
    );

    modport slave (
        input  start, expected, dut_out,
        output stim, busy, done, result, match, unstable
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps every input row of a combinational netlist, holds each SETTLE_CYCLES, packs the truth table (row 0 in MSB).
// Optional TT_SWEEP_STABILITY_CHECK_EN adds a second per-row sample and a sticky unstable flag.
module truth_table_sweeper #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input logic                  clk,
    input logic                  rst,
    truth_table_sweeper_if.slave bus
);
    localparam int ROWS = 1 << N_IN;
    localparam int CW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] ROW_LAST = '1;

    if (N_IN < 1 || N_IN > 4 || SETTLE_CYCLES < 1) begin : g_param_err
        $error("truth_table_sweeper: N_IN must be 1..4 and SETTLE_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t            state, state_nxt;
    logic [N_IN-1:0]   row;
    logic [CW-1:0]     cnt;
    logic [ROWS-1:0]   exp_q;
    logic [ROWS-1:0]   result_q;
    logic [ROWS-1:0]   result_nxt;
    logic              match_q;
    logic              unstable_nxt;
    logic              sample;
    logic              last;

    assign sample = (state == SETTLE) && (cnt == CNT_LAST);
    assign last   = sample && (row == ROW_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SETTLE;
            SETTLE:  if (last)      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Row i lands at bit ROWS-1-i, which is simply the bitwise inverse of the row index.
    always_comb begin
        result_nxt       = result_q;
        result_nxt[~row] = bus.dut_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row      <= '0;
            cnt      <= '0;
            exp_q    <= '0;
            result_q <= '0;
            match_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        exp_q    <= bus.expected;
                        result_q <= '0;
                        match_q  <= 1'b0;
                        row      <= '0;
                        cnt      <= '0;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 1'b1;
                    if (sample) begin
                        result_q <= result_nxt;
                        cnt      <= '0;
                        if (row == ROW_LAST) begin
                            row     <= '0;
                            match_q <= (result_nxt == exp_q) && !unstable_nxt;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TT_SWEEP_STABILITY_CHECK_EN
    localparam logic [CW-1:0] CNT_EARLY = CW'(SETTLE_CYCLES - 2);
    logic early_q;
    logic unstable_q;

    if (SETTLE_CYCLES < 2) begin : g_stab_cfg_err
        $error("truth_table_sweeper: stability check needs SETTLE_CYCLES >= 2");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            early_q    <= 1'b0;
            unstable_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            unstable_q <= 1'b0;
        end else if (state == SETTLE) begin
            if (cnt == CNT_EARLY) early_q <= bus.dut_out;
            if (sample)           unstable_q <= unstable_nxt;
        end
    end

    assign unstable_nxt = unstable_q | (sample && (early_q != bus.dut_out));
    assign bus.unstable = unstable_q;
`else
    assign unstable_nxt = 1'b0;
    assign bus.unstable = 1'b0;
`endif

    assign bus.stim   = row;
    assign bus.busy   = (state == SETTLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
    assign bus.match  = match_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: stimulus pushes expected tables, a negedge monitor checks them on done.
module tb_truth_table_sweeper;
    localparam int N    = 3;
    localparam int S    = 4;
    localparam int ROWS = 1 << N;
    localparam int SWEEP_CYC = ROWS * S;

`ifdef TT_SWEEP_STABILITY_CHECK_EN
    localparam bit STAB = 1'b1;
`else
    localparam bit STAB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(N)) bus();

    truth_table_sweeper #(.N_IN(N), .SETTLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Netlist models: 0 = 0xC2 NOR/NOT circuit, 1 = constant 1, 2 = buffer of in3, 3 = 0xC2 with a glitch at row 2
    int mode;
    int cyc;
    logic c2;
    always_comb begin
        c2 = (~bus.stim[2] & ~bus.stim[1]) | (bus.stim[2] & bus.stim[1] & ~bus.stim[0]);
        case (mode)
            1:       bus.dut_out = 1'b1;
            2:       bus.dut_out = bus.stim[0];
            3:       bus.dut_out = c2 ^ (cyc == 2 * S + S - 1);
            default: bus.dut_out = c2;
        endcase
    end

    // cyc = j in the j-th cycle after the accepting edge; row = (j-1)/S
    always @(posedge clk) begin
        if (bus.start && !bus.busy && !bus.done && !rst) cyc <= 1;
        else                                             cyc <= cyc + 1;
    end

    typedef struct {
        logic [ROWS-1:0] res;
        logic            mt;
        logic            un;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    endtask

    int busy_cnt = 0;
    int stim_err = 0;
    int done_seen = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.busy) begin
                busy_cnt++;
                if (int'(bus.stim) != (cyc - 1) / S) stim_err++;
            end
            if (bus.done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    chk("spurious_done", bus.done, 0);
                end else begin
                    exp_t  e;
                    string nm;
                    e  = sb.pop_front();
                    nm = sb_name.pop_front();
                    chk({nm, "_result"},   bus.result,   e.res);
                    chk({nm, "_match"},    bus.match,    e.mt);
                    chk({nm, "_unstable"}, bus.unstable, e.un);
                    chk({nm, "_done_cyc"}, cyc,          SWEEP_CYC + 1);
                    chk({nm, "_busy_len"}, busy_cnt,     SWEEP_CYC);
                    chk({nm, "_stim_seq"}, stim_err,     0);
                end
            end
            if (!bus.busy && !bus.done) begin
                busy_cnt = 0;
                stim_err = 0;
            end
        end
    end

    task automatic wait_done(input string name);
        bit got = 0;
        for (int i = 0; i < SWEEP_CYC + 20 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1;
        end
        if (!got) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic sweep(input string name, input int m, input logic [ROWS-1:0] expv,
                         input logic [ROWS-1:0] res, input logic mt, input logic un);
        exp_t e;
        mode         = m;
        bus.expected = expv;
        bus.start    = 1'b1;
        e.res = res; e.mt = mt; e.un = un;
        sb.push_back(e);
        sb_name.push_back(name);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(name);
        @(negedge clk);
        chk({name, "_hold_result"}, bus.result, res);
        chk({name, "_idle_stim"},   bus.stim,   0);
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < SWEEP_CYC + 10 && cyc != target; i++) @(negedge clk);
        chk("wait_cyc_reached", cyc, target);
    endtask

    initial begin
        rst          = 1'b1;
        mode         = 0;
        bus.start    = 1'b0;
        bus.expected = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_stim",     bus.stim,     0);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_done",     bus.done,     0);
        chk("rst_result",   bus.result,   0);
        chk("rst_match",    bus.match,    0);
        chk("rst_unstable", bus.unstable, 0);
        @(negedge clk);

        sweep("c2_exp_c2", 0, 8'hC2, 8'hC2, 1'b1, 1'b0);
        sweep("c2_exp_c3", 0, 8'hC3, 8'hC2, 1'b0, 1'b0);
        sweep("const1",    1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        sweep("buf_in3",   2, 8'h55, 8'h55, 1'b1, 1'b0);

        // Re-pulse start mid-sweep, then abort with reset at row 5
        mode         = 0;
        bus.expected = 8'hC2;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cyc(3 * S + 1);
        bus.expected = 8'h00;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cyc(5 * S + 1);
        chk("abort_stim_row5", bus.stim, 5);
        chk("abort_busy_pre",  bus.busy, 1);
        done_seen = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_stim",     bus.stim,     0);
        chk("abort_busy",     bus.busy,     0);
        chk("abort_done",     bus.done,     0);
        chk("abort_result",   bus.result,   0);
        chk("abort_match",    bus.match,    0);
        chk("abort_unstable", bus.unstable, 0);
        repeat (SWEEP_CYC + 8) @(negedge clk);
        chk("abort_no_done", done_seen, 0);

        sweep("after_abort", 0, 8'hC2, 8'hC2, 1'b1, 1'b0);
        sweep("glitch_r2",   3, 8'hC2, 8'hC2, !STAB, STAB);
        sweep("post_glitch", 0, 8'hC2, 8'hC2, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end
endmodule
